// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed big-endian byte stream into
// one-cycle 32-bit word writes at byte addresses 0,4,8,... and holds the CPU meanwhile.
module imem_loader #(
    parameter int unsigned WORDS  = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow
);

    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state_q,      state_d;
    logic [CNT_W-1:0]  count_q,      count_d;
    logic [CNT_W-1:0]  index_q,      index_d;
    logic [1:0]        bcnt_q,       bcnt_d;
    logic [31:0]       word_q,       word_d;
    logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
    logic [31:0]       wr_data_q,    wr_data_d;
    logic              wr_en_q,      wr_en_d;
    logic              byte_ready_q, byte_ready_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              overflow_q,   overflow_d;
    logic              xfer;

    // byte_ready_q always mirrors the readiness of state_q, so it qualifies the transfer.
    assign xfer = byte_valid & byte_ready_q;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            index_q      <= '0;
            bcnt_q       <= '0;
            word_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            index_q      <= index_d;
            bcnt_q       <= bcnt_d;
            word_q       <= word_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        bcnt_d     = bcnt_q;
        word_d     = word_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    index_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    count_d = {byte_in, count_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    count_d    = {count_q[15:8], byte_in};
                    overflow_d = overflow_q | (32'(count_d) > 32'(WORDS));
                    bcnt_d     = '0;
                    state_d    = (count_d == '0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d = {word_q[23:0], byte_in};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d   = S_WRITE;
                        wr_data_d = word_d;
                        wr_addr_d = ADDR_W'({16'd0, index_q} << 2);
                        wr_en_d   = (32'(index_q) < 32'(WORDS));
                    end
                end
            end
            S_WRITE: begin
                index_d = index_q + 16'd1;
                bcnt_d  = '0;
                state_d = (index_q == count_q - 16'd1) ? S_DONE : S_DATA;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        byte_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA);
        busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d       = (state_d == S_DONE);
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign cpu_hold   = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a full-size instance and a WORDS=2 instance share one byte stream.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        byte_ready, wr_en, busy, cpu_hold, done, overflow;
    logic [31:0] wr_addr, wr_data;
    logic        s_byte_ready, s_wr_en, s_busy, s_cpu_hold, s_done, s_overflow;
    logic [31:0] s_wr_addr, s_wr_data;

    int checks = 0;
    int errors = 0;

    imem_loader #(.WORDS(256), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .overflow(overflow)
    );

    imem_loader #(.WORDS(2), .ADDR_W(32)) dut_s (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(s_byte_ready), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .busy(s_busy), .cpu_hold(s_cpu_hold), .done(s_done), .overflow(s_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Sends one word and checks the write strobe in the cycle after its 4th byte.
    task automatic send_word(input logic [31:0] w, input int idx, input int maxgap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8]);
            if (k < 3 && maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge clk);
        end
        chk("wr_en", 32'(wr_en), 32'(idx < 256));
        chk("wr_addr", wr_addr, 32'(idx * 4));
        chk("wr_data", wr_data, w);
        chk("ready_in_write", 32'(byte_ready), 32'd0);
        chk("s_wr_en", 32'(s_wr_en), 32'(idx < 2));
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_ready", 32'(byte_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_addr"}, wr_addr, 32'd0);
        chk({tag, "_data"}, wr_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_s_ovf"}, 32'(s_overflow), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        // Bytes offered while idle are not consumed.
        byte_in    = 8'hAA;
        byte_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(byte_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        byte_valid = 1'b0;

        // Two-word load
        do_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h8001060A, 0, 0);
        send_word(32'h04011000, 1, 0);
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_hold", 32'(cpu_hold), 32'd0);
        chk("t1_wr_en", 32'(wr_en), 32'd0);
        chk("t1_ovf", 32'(overflow), 32'd0);
        chk("t1_s_ovf", 32'(s_overflow), 32'd0);

        // Empty program: DONE right after the second header byte
        do_start();
        send_byte(8'h00);
        send_byte(8'h00);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_wr_en", 32'(wr_en), 32'd0);
        chk("t2_ovf", 32'(overflow), 32'd0);

        // Three words into the WORDS=2 instance
        do_start();
        send_byte(8'h00);
        send_byte(8'h03);
        chk("t3_s_ovf", 32'(s_overflow), 32'd1);
        chk("t3_ovf", 32'(overflow), 32'd0);
        send_word(32'h11223344, 0, 0);
        send_word(32'h55667788, 1, 0);
        send_word(32'h99AABBCC, 2, 0);
        @(negedge clk);
        chk("t3_s_done", 32'(s_done), 32'd1);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_s_ovf_held", 32'(s_overflow), 32'd1);

        // 64 words with random byte gaps
        do_start();
        send_byte(8'h00);
        send_byte(8'h40);
        for (int i = 0; i < 64; i++) begin
            send_word(32'(i) * 32'h9E3779B1 + 32'h01020304, i, 7);
            if (i < 63) repeat ($urandom_range(7, 0)) @(negedge clk);
        end
        @(negedge clk);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);

        // Reset in the middle of word 5
        do_start();
        send_byte(8'h00);
        send_byte(8'h08);
        for (int i = 0; i < 5; i++) send_word(32'hC0DE0000 + 32'(i), i, 0);
        send_byte(8'hDE);
        send_byte(8'hAD);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t5_rst");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_no_write", 32'(wr_en), 32'd0);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        // start together with a valid byte: the byte must not count as the header
        start      = 1'b1;
        byte_in    = 8'h77;
        byte_valid = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        chk("t5_busy", 32'(busy), 32'd1);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'hFEEDBEEF, 0, 0);
        send_word(32'h0BADF00D, 1, 0);
        @(negedge clk);
        chk("t5_done", 32'(done), 32'd1);

        // start during DATA is ignored; start in DONE restarts
        do_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'hA1A2A3A4, 0, 0);
        send_byte(8'hB1);
        send_byte(8'hB2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_busy_kept", 32'(busy), 32'd1);
        chk("t6_ready_kept", 32'(byte_ready), 32'd1);
        send_byte(8'hB3);
        send_byte(8'hB4);
        chk("t6_wr_en", 32'(wr_en), 32'd1);
        chk("t6_addr", wr_addr, 32'd4);
        chk("t6_data", wr_data, 32'hB1B2B3B4);
        @(negedge clk);
        chk("t6_done", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_restart_done", 32'(done), 32'd0);
        chk("t6_restart_busy", 32'(busy), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("t6_final_done", 32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
